// File: rtl/hps_result_reader_if.sv
// HPS read bus between the bridge (master) and the result reader (slave).
// One word is requested per cycle the request is high; data returns one cycle later.
interface hps_result_reader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int IDX_WIDTH  = 5
);
    logic                  hps_rd_req_i;
    logic [IDX_WIDTH-1:0]  hps_rd_index_i;
    logic [DATA_WIDTH-1:0] hps_rd_data_o;
    logic                  hps_rd_valid_o;

    modport master (
        output hps_rd_req_i,
        output hps_rd_index_i,
        input  hps_rd_data_o,
        input  hps_rd_valid_o
    );

    modport slave (
        input  hps_rd_req_i,
        input  hps_rd_index_i,
        output hps_rd_data_o,
        output hps_rd_valid_o
    );
endinterface

// File: rtl/hps_result_reader.sv
// Readout side of the HPS/accelerator link: counts fully-connected hold edges,
// snapshots the logits, finds their argmax serially and serves the snapshot
// to the HPS over a registered read port.
module hps_result_reader #(
    parameter int DATA_WIDTH        = 32,
    parameter int N_NEURONS         = 10,
    parameter int N_OUTPUTS_LAYER_1 = 75,
    parameter int SETTLE_CYCLES     = 4,
    parameter int IDX_WIDTH         = 5
) (
    input  logic                               system_clock,
    input  logic                               global_reset,
    input  logic                               start_i,
    input  logic                               hold_data_fc_i,
    input  logic signed [DATA_WIDTH-1:0]       logits_i [N_NEURONS],
    hps_result_reader_if.slave                 hps,
    input  logic                               hps_release_i,
    output logic                               result_ready_o,
    output logic [$clog2(N_NEURONS)-1:0]       argmax_o,
    output logic                               busy_o,
    output logic                               next_input_o
);
    localparam int AW = $clog2(N_NEURONS);
    localparam int CW = $clog2(N_OUTPUTS_LAYER_1 + 1);
    localparam int SW = $clog2(SETTLE_CYCLES + 2);

    typedef enum logic [2:0] {
        S_IDLE, S_COUNT, S_SETTLE, S_LATCH, S_ARGMAX, S_READY, S_DONE
    } state_t;

    state_t                       state_reg;
    logic [CW-1:0]                hold_cnt_reg;
    logic [SW-1:0]                settle_cnt_reg;
    logic                         edge_reg;
    logic [AW-1:0]                k_reg;
    logic [AW-1:0]                best_idx_reg;
    logic signed [DATA_WIDTH-1:0] best_reg;
    logic signed [DATA_WIDTH-1:0] snapshot_reg [N_NEURONS];

    logic                         cand_gt;
    logic [DATA_WIDTH-1:0]        rd_word_next;
    logic [7:0]                   hold_sat;

    // Snapshot registers: each word loads its logit during the single LATCH cycle
    generate
        for (genvar gi = 0; gi < N_NEURONS; gi++) begin : g_snap
            // Capture logit gi in LATCH, otherwise hold the previous image
            always_ff @(posedge system_clock or posedge global_reset) begin
                if (global_reset)
                    snapshot_reg[gi] <= '0;
                else if (state_reg == S_LATCH)
                    snapshot_reg[gi] <= logits_i[gi];
            end
        end
    endgenerate

    // Signed strictly-greater test of the current candidate; ties keep the lower index
    always_comb begin
        cand_gt = snapshot_reg[k_reg] > best_reg;
    end

    // Control FSM with registered status outputs and the serial argmax datapath
    always_ff @(posedge system_clock or posedge global_reset) begin
        if (global_reset) begin
            state_reg      <= S_IDLE;
            hold_cnt_reg   <= '0;
            settle_cnt_reg <= '0;
            edge_reg       <= 1'b0;
            k_reg          <= '0;
            best_idx_reg   <= '0;
            best_reg       <= '0;
            result_ready_o <= 1'b0;
            argmax_o       <= '0;
            busy_o         <= 1'b0;
            next_input_o   <= 1'b0;
        end else begin
            edge_reg     <= hold_data_fc_i;
            next_input_o <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start_i) begin
                        state_reg    <= S_COUNT;
                        hold_cnt_reg <= '0;
                        edge_reg     <= 1'b0;
                        busy_o       <= 1'b1;
                    end
                end
                S_COUNT: begin
                    // The full count is acted on one cycle after it is reached
                    if (hold_cnt_reg == CW'(N_OUTPUTS_LAYER_1)) begin
                        state_reg      <= S_SETTLE;
                        settle_cnt_reg <= SW'(SETTLE_CYCLES);
                    end else if (hold_data_fc_i && !edge_reg) begin
                        hold_cnt_reg <= hold_cnt_reg + 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt_reg <= SW'(1)) begin
                        settle_cnt_reg <= '0;
                        state_reg      <= S_LATCH;
                        busy_o         <= 1'b0;
                    end else begin
                        settle_cnt_reg <= settle_cnt_reg - 1'b1;
                    end
                end
                S_LATCH: begin
                    // best starts as logit 0, which is what snapshot[0] receives now
                    best_reg     <= logits_i[0];
                    best_idx_reg <= '0;
                    k_reg        <= AW'(1);
                    state_reg    <= S_ARGMAX;
                    busy_o       <= 1'b1;
                end
                S_ARGMAX: begin
                    if (cand_gt) begin
                        best_reg     <= snapshot_reg[k_reg];
                        best_idx_reg <= k_reg;
                    end
                    if (k_reg == AW'(N_NEURONS - 1)) begin
                        state_reg      <= S_READY;
                        busy_o         <= 1'b0;
                        result_ready_o <= 1'b1;
                        argmax_o       <= cand_gt ? k_reg : best_idx_reg;
                    end else begin
                        k_reg <= k_reg + 1'b1;
                    end
                end
                S_READY: begin
                    if (hps_release_i) begin
                        state_reg      <= S_DONE;
                        result_ready_o <= 1'b0;
                        next_input_o   <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    // Read map decode: snapshot words, argmax, status, zero elsewhere
    always_comb begin
        rd_word_next = '0;
        hold_sat     = (32'(hold_cnt_reg) > 32'd255) ? 8'hFF : 8'(hold_cnt_reg);
        for (int n = 0; n < N_NEURONS; n++) begin
            if (int'(hps.hps_rd_index_i) == n)
                rd_word_next = snapshot_reg[n];
        end
        if (int'(hps.hps_rd_index_i) == N_NEURONS) begin
            rd_word_next = DATA_WIDTH'(argmax_o);
        end else if (int'(hps.hps_rd_index_i) == N_NEURONS + 1) begin
            rd_word_next[0]    = result_ready_o;
            rd_word_next[1]    = busy_o;
            rd_word_next[15:8] = hold_sat;
        end
    end

    // Registered read port: one valid word per request, one cycle later
    always_ff @(posedge system_clock or posedge global_reset) begin
        if (global_reset) begin
            hps.hps_rd_data_o  <= '0;
            hps.hps_rd_valid_o <= 1'b0;
        end else begin
            hps.hps_rd_valid_o <= hps.hps_rd_req_i;
            if (hps.hps_rd_req_i)
                hps.hps_rd_data_o <= rd_word_next;
        end
    end
endmodule

// File: tb/tb_hps_result_reader.sv
// Bench for hps_result_reader: table of images with expected argmax,
// read scoreboard, and hand-written reset / release / hold-filter sequences.
module tb_hps_result_reader;
    logic        system_clock = 1'b0;
    logic        global_reset;
    logic        start_i;
    logic        hold_data_fc_i;
    logic signed [31:0] logits [10];
    logic        hps_release_i;
    logic        result_ready_o;
    logic [3:0]  argmax_o;
    logic        busy_o;
    logic        next_input_o;

    hps_result_reader_if #(.DATA_WIDTH(32), .IDX_WIDTH(5)) hps_bus ();

    hps_result_reader dut (
        .system_clock   (system_clock),
        .global_reset   (global_reset),
        .start_i        (start_i),
        .hold_data_fc_i (hold_data_fc_i),
        .logits_i       (logits),
        .hps            (hps_bus),
        .hps_release_i  (hps_release_i),
        .result_ready_o (result_ready_o),
        .argmax_o       (argmax_o),
        .busy_o         (busy_o),
        .next_input_o   (next_input_o)
    );

    always #5 system_clock = ~system_clock;

    typedef struct packed {
        logic [9:0][31:0] lg;
        logic [3:0]       exp_arg;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] data;
    } rd_exp_t;

    vec_t        vecs [5];
    rd_exp_t     sb [$];
    logic [31:0] prev_snap [10];
    int          n_vec = 0;
    int          n_err = 0;
    int          valid_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge system_clock);
        #1;
    endtask

    // Drive a read request for the next edge and queue its expected word
    task automatic issue_read(input int idx, input logic [31:0] exp);
        rd_exp_t e;
        e.idx = idx;
        e.data = exp;
        sb.push_back(e);
        hps_bus.hps_rd_req_i   = 1'b1;
        hps_bus.hps_rd_index_i = 5'(idx);
    endtask

    // Read monitor: every valid word must match the oldest queued expectation
    always @(negedge system_clock) begin
        if (hps_bus.hps_rd_valid_o) begin
            valid_count++;
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL rd_unexpected: got valid with data 0x%08h want no valid",
                         hps_bus.hps_rd_data_o);
            end else begin
                rd_exp_t e;
                e = sb.pop_front();
                check($sformatf("rd_idx%0d", e.idx), hps_bus.hps_rd_data_o, e.data);
            end
        end
    end

    task automatic run_image(input int vi, input bit long_first, input bit release_mid,
                             input bit settle_edges, input bit abort40);
        int cycles;
        int vc0;
        for (int k = 0; k < 10; k++) logits[k] = vecs[vi].lg[k];
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("busy_after_start", 32'(busy_o), 32'd1);
        for (int p = 1; p <= 75; p++) begin
            if (abort40 && p == 41) begin
                global_reset = 1'b1;
                #1;
                check("abort_ready", 32'(result_ready_o), 32'd0);
                check("abort_busy", 32'(busy_o), 32'd0);
                check("abort_argmax", 32'(argmax_o), 32'd0);
                check("abort_next", 32'(next_input_o), 32'd0);
                check("abort_valid", 32'(hps_bus.hps_rd_valid_o), 32'd0);
                tick();
                global_reset = 1'b0;
                tick();
                for (int k = 0; k < 10; k++) prev_snap[k] = 32'd0;
                issue_read(11, 32'h0000_0000);
                tick();
                issue_read(1, 32'h0000_0000);
                tick();
                hps_bus.hps_rd_req_i = 1'b0;
                tick();
                check("abort_next_after", 32'(next_input_o), 32'd0);
                return;
            end
            hold_data_fc_i = 1'b1;
            tick();
            if (long_first && p == 1) begin
                for (int j = 0; j < 4; j++) tick();
            end
            if (p == 75) break;
            for (int j = 0; j < 3; j++) begin
                hold_data_fc_i = 1'b0;
                if (p == 1 && j == 0) issue_read(11, 32'h0000_0102);
                if (p == 1 && j == 1) issue_read(1, prev_snap[1]);
                if (release_mid && p == 10 && j == 0) hps_release_i = 1'b1;
                tick();
                hps_bus.hps_rd_req_i = 1'b0;
                hps_release_i = 1'b0;
                if (release_mid && p == 10 && j == 0) begin
                    check("release_in_count_next", 32'(next_input_o), 32'd0);
                    check("release_in_count_busy", 32'(busy_o), 32'd1);
                end
            end
        end
        // Final hold edge has just been counted; measure latency to ready
        hold_data_fc_i = 1'b0;
        cycles = 0;
        while (!result_ready_o && cycles < 40) begin
            hold_data_fc_i = settle_edges && (cycles == 1 || cycles == 3);
            tick();
            cycles++;
        end
        hold_data_fc_i = 1'b0;
        check("latency", 32'(cycles), 32'd15);
        check("argmax", 32'(argmax_o), 32'(vecs[vi].exp_arg));
        vc0 = valid_count;
        issue_read(10, 32'(vecs[vi].exp_arg));
        tick();
        for (int i = 0; i < 12; i++) begin
            if (i < 10) issue_read(i, vecs[vi].lg[i]);
            else if (i == 10) issue_read(10, 32'(vecs[vi].exp_arg));
            else issue_read(11, 32'h0000_4B01);
            tick();
        end
        issue_read(31, 32'h0000_0000);
        tick();
        hps_bus.hps_rd_req_i = 1'b0;
        tick();
        check("burst_valid_count", 32'(valid_count - vc0), 32'd14);
        check("ready_held", 32'(result_ready_o), 32'd1);
        // Release together with a read: read still comes from the snapshot
        hps_release_i = 1'b1;
        issue_read(vi % 10, vecs[vi].lg[vi % 10]);
        tick();
        hps_release_i = 1'b0;
        hps_bus.hps_rd_req_i = 1'b0;
        check("done_ready", 32'(result_ready_o), 32'd0);
        check("done_next", 32'(next_input_o), 32'd1);
        tick();
        check("next_one_cycle", 32'(next_input_o), 32'd0);
        issue_read(11, 32'h0000_4B00);
        tick();
        hps_bus.hps_rd_req_i = 1'b0;
        tick();
        for (int k = 0; k < 10; k++) prev_snap[k] = vecs[vi].lg[k];
    endtask

    initial begin
        // Logits listed index 9 first
        vecs[0].lg = {32'h0000_2e0b, 32'h0000_0000, 32'hFFFF_0000, 32'h0000_2000, 32'h0000_0100,
                      32'hFFFF_E000, 32'h0000_1a00, 32'hFFFF_F796, 32'h0000_2e0c, 32'h0000_0c74};
        vecs[0].exp_arg = 4'd1;
        vecs[1].lg = {32'hFFFF_F000, 32'hFFFF_FE80, 32'hFFFF_FF00, 32'hFFFF_FC00, 32'h8000_0001,
                      32'hFFFF_FD00, 32'hFFFF_FEFF, 32'h8000_0000, 32'hFFFF_FE00, 32'hFFFF_F000};
        vecs[1].exp_arg = 4'd7;
        vecs[2].lg = {32'h0000_0010, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_7000, 32'h0000_6fff,
                      32'h0000_0002, 32'h0000_7000, 32'hFFFF_FFFD, 32'h0000_0064, 32'h0000_0005};
        vecs[2].exp_arg = 4'd3;
        vecs[3].lg = {32'h0000_0001, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000,
                      32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
        vecs[3].exp_arg = 4'd9;
        vecs[4].lg = {10{32'h0000_0055}};
        vecs[4].exp_arg = 4'd0;
        for (int k = 0; k < 10; k++) begin
            prev_snap[k] = 32'd0;
            logits[k] = '0;
        end

        global_reset = 1'b1;
        start_i = 1'b0;
        hold_data_fc_i = 1'b0;
        hps_release_i = 1'b0;
        hps_bus.hps_rd_req_i = 1'b0;
        hps_bus.hps_rd_index_i = '0;
        tick();
        tick();
        global_reset = 1'b0;
        tick();
        check("rst_ready", 32'(result_ready_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_argmax", 32'(argmax_o), 32'd0);
        check("rst_next", 32'(next_input_o), 32'd0);
        check("rst_valid", 32'(hps_bus.hps_rd_valid_o), 32'd0);
        issue_read(11, 32'h0000_0000);
        tick();
        issue_read(0, 32'h0000_0000);
        tick();
        issue_read(10, 32'h0000_0000);
        tick();
        hps_bus.hps_rd_req_i = 1'b0;
        tick();

        run_image(0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_image(1, 1'b0, 1'b0, 1'b0, 1'b1);
        run_image(1, 1'b0, 1'b1, 1'b0, 1'b0);
        run_image(2, 1'b1, 1'b0, 1'b0, 1'b0);
        run_image(3, 1'b0, 1'b0, 1'b1, 1'b0);
        run_image(4, 1'b0, 1'b0, 1'b0, 1'b0);

        tick();
        tick();
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
